mem_rr_controller: RTL and testbench

Parametrised successor to the single-channel memory controller. Serves NCH request FIFOs with round-robin arbitration against an internal word-addressed backing store. Pushes tagged responses {err, channel, TID, data} into one response FIFO. Sits between the per-port request FIFOs and the shared response FIFO of the memory-side datapath.

---
 rtl/mem_rr_controller.sv | 164 ++++++++++++++++
 tb/tb_mem_rr_controller.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rr_controller.sv
// Round-robin arbiter over NCH request FIFOs with a word-addressed backing store.
// One transaction in flight; tagged responses go to a single response FIFO.
module mem_rr_controller #(
  parameter int NCH        = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 31,
  parameter int TID_WIDTH  = 16,
  parameter int MEM_DEPTH  = 256,
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int REQ_W = TID_WIDTH + 1 + ADDR_WIDTH + DATA_WIDTH,
  localparam int RSP_W = 1 + CH_W + TID_WIDTH + DATA_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NCH-1:0]     req_empty,
  output logic [NCH-1:0]     req_rd_en,
  input  logic [NCH*REQ_W-1:0] req_data,
  input  logic               rsp_full,
  output logic               rsp_wr_en,
  output logic [RSP_W-1:0]   rsp_data,
  output logic               busy,
  output logic [15:0]        done_count
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int IW = (AW > 0) ? AW : 1;

  typedef struct packed {
    logic [TID_WIDTH-1:0]  tid;
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_ACCESS,
    S_RESPOND
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CH_W-1:0]       r_ptr;
  logic [CH_W-1:0]       r_grant;
  req_t                  r_req;
  logic [RSP_W-1:0]      r_rsp_data;
  logic [15:0]           r_done_count;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_found;
  logic [CH_W-1:0]       w_pick;
  logic [NCH-1:0]        w_rd_en;
  logic                  w_push;
  req_t                  w_slice;
  logic [CH_W-1:0]       w_ptr_inc;
  logic                  w_err;
  logic [IW-1:0]         w_idx;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Nearest non-empty channel at or after the pointer, modulo NCH.
  always_comb begin
    int best_d;
    int d;
    best_d  = NCH;
    d       = 0;
    w_pick  = '0;
    for (int j = 0; j < NCH; j++) begin
      if (!req_empty[j]) begin
        d = (j - int'(r_ptr) + NCH) % NCH;
        if (d < best_d) begin
          best_d = d;
          w_pick = CH_W'(j);
        end
      end
    end
    w_found = (best_d < NCH);
  end

  assign w_slice   = req_t'(req_data[int'(r_grant)*REQ_W +: REQ_W]);
  assign w_ptr_inc = (int'(r_grant) == NCH - 1) ? '0 : r_grant + CH_W'(1);
  assign w_err     = ((r_req.addr >> AW) != '0);
  assign w_idx     = r_req.addr[IW-1:0];

  always_comb begin
    w_rdata = '0;
    if (!w_err) begin
      w_rdata = r_req.wr ? r_req.data : r_mem[w_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_rd_en = '0;
    w_push  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          for (int j = 0; j < NCH; j++) begin
            w_rd_en[j] = (CH_W'(j) == w_pick);
          end
          w_next = S_CAPTURE;
        end
      end
      S_CAPTURE: w_next = S_ACCESS;
      S_ACCESS:  w_next = S_RESPOND;
      S_RESPOND: begin
        if (!rsp_full) begin
          w_push = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr        <= '0;
      r_grant      <= '0;
      r_req        <= '0;
      r_rsp_data   <= '0;
      r_done_count <= '0;
    end else begin
      if (r_state == S_IDLE && w_found) begin
        r_grant <= w_pick;
      end
      if (r_state == S_CAPTURE) begin
        r_req <= w_slice;
        r_ptr <= w_ptr_inc;
      end
      if (r_state == S_ACCESS) begin
        r_rsp_data <= {w_err, r_grant, r_req.tid, w_rdata};
      end
      if (w_push) begin
        r_done_count <= r_done_count + 16'd1;
      end
    end
  end

  // Backing store is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (r_state == S_ACCESS && r_req.wr && !w_err) begin
      r_mem[w_idx] <= r_req.data;
    end
  end

  // Pop is combinational from IDLE, so mask it while reset is held.
  assign req_rd_en  = reset ? '0 : w_rd_en;
  assign rsp_wr_en  = w_push;
  assign rsp_data   = r_rsp_data;
  assign busy       = (r_state != S_IDLE);
  assign done_count = r_done_count;

endmodule

// File: tb/tb_mem_rr_controller.sv
// Bench for mem_rr_controller: FIFO models, queue-based reference model,
// directed scenarios then randomized traffic with random backpressure.
module tb_mem_rr_controller;

  localparam int NCH   = 4;
  localparam int DW    = 32;
  localparam int AWD   = 31;
  localparam int TW    = 16;
  localparam int DEPTH = 256;
  localparam int CH_W  = 2;
  localparam int REQ_W = TW + 1 + AWD + DW;
  localparam int RSP_W = 1 + CH_W + TW + DW;

  typedef logic [REQ_W-1:0] req_t;
  typedef logic [RSP_W-1:0] rsp_t;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NCH-1:0]       req_empty = '1;
  logic [NCH-1:0]       req_rd_en;
  logic [NCH*REQ_W-1:0] req_data = '0;
  logic                 rsp_full = 1'b0;
  logic                 rsp_wr_en;
  logic [RSP_W-1:0]     rsp_data;
  logic                 busy;
  logic [15:0]          done_count;

  mem_rr_controller #(
    .NCH(NCH), .DATA_WIDTH(DW), .ADDR_WIDTH(AWD),
    .TID_WIDTH(TW), .MEM_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .req_empty(req_empty), .req_rd_en(req_rd_en),
    .req_data(req_data),
    .rsp_full(rsp_full), .rsp_wr_en(rsp_wr_en),
    .rsp_data(rsp_data), .busy(busy),
    .done_count(done_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  req_t        q [NCH][$];
  rsp_t        exp_q [$];
  logic [DW-1:0] m_mem [DEPTH];
  int          m_ptr = 0;
  logic [15:0] m_done = '0;
  int          cyc = 0;
  bit          pop_pending = 0;
  int          pop_ch = 0;
  int          pop_cycle = -100;
  int          n_pops = 0;
  int          gnt_log [$];
  rsp_t        last_rsp = '0;
  bit          rand_bp = 0;
  bit          bp_force = 0;

  task automatic push(int k, logic [TW-1:0] tid, bit wr,
                      logic [AWD-1:0] addr, logic [DW-1:0] data);
    q[k].push_back({tid, wr, addr, data});
  endtask

  // Reference: apply the request's effect and predict its response.
  task automatic model(int k, req_t it);
    logic [TW-1:0]  tid;
    logic           wr;
    logic [AWD-1:0] addr;
    logic [DW-1:0]  d;
    bit             err;
    tid  = it[REQ_W-1 -: TW];
    wr   = it[DW+AWD];
    addr = it[DW +: AWD];
    err  = (addr >= AWD'(DEPTH));
    d    = '0;
    if (!err && wr) begin
      m_mem[addr[7:0]] = it[DW-1:0];
      d = it[DW-1:0];
    end else if (!err) begin
      d = m_mem[addr[7:0]];
    end
    exp_q.push_back({err, CH_W'(k), tid, d});
  endtask

  // Request FIFO model: data appears the cycle after the pop.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!reset && pop_pending) begin
      req_t it;
      if (q[pop_ch].size() == 0) begin
        chk("pop_empty", 64'd1, 64'd0);
      end else begin
        it = q[pop_ch].pop_front();
        req_data[pop_ch*REQ_W +: REQ_W] = it;
        model(pop_ch, it);
      end
      pop_pending = 0;
    end
    for (int j = 0; j < NCH; j++) req_empty[j] = (q[j].size() == 0);
    rsp_full = rand_bp ? ($urandom_range(0, 3) == 0) : bp_force;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (exp_q.size() > 0 && cyc - pop_cycle >= 3) begin
        chk("rsp_data", 64'(rsp_data), 64'(exp_q[0]));
        chk("rsp_wr_en", 64'(rsp_wr_en), 64'(!rsp_full));
        if (rsp_wr_en) begin
          last_rsp = rsp_data;
          void'(exp_q.pop_front());
          m_done++;
        end
      end else if (rsp_wr_en) begin
        chk("early_push", 64'd1, 64'd0);
      end
      if (|req_rd_en) begin
        int k;
        int e;
        k = 0;
        e = -1;
        for (int j = 0; j < NCH; j++) if (req_rd_en[j]) k = j;
        for (int i = NCH - 1; i >= 0; i--)
          if (!req_empty[(m_ptr + i) % NCH]) e = (m_ptr + i) % NCH;
        chk("rd_onehot", 64'($onehot(req_rd_en)), 64'd1);
        chk("grant", 64'(k), 64'(e));
        chk("pop_in_flight", 64'(exp_q.size()), 64'd0);
        m_ptr = (k + 1) % NCH;
        gnt_log.push_back(k);
        pop_pending = 1;
        pop_ch = k;
        pop_cycle = cyc;
        n_pops++;
      end
    end
  end

  task automatic wait_idle(int max);
    bit ok;
    ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = !busy && exp_q.size() == 0 && !pop_pending &&
           (&req_empty) && req_rd_en == '0;
      for (int j = 0; j < NCH; j++) if (q[j].size() != 0) ok = 0;
    end
    if (!ok) chk("idle_timeout", 64'd0, 64'd1);
    else chk("done_count", 64'(done_count), 64'(m_done));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    exp_q.delete();
    m_ptr = 0;
    m_done = '0;
    pop_pending = 0;
    @(posedge clk);
    #3 reset = 1'b0;
  endtask

  initial begin
    int   exp6 [4];
    int   p0;
    bit   seen;
    rsp_t held;
    exp6 = '{3, 1, 2, 0};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd_en", 64'(req_rd_en), 64'd0);
    chk("rst_wr_en", 64'(rsp_wr_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done_count), 64'd0);
    chk("rst_rsp", 64'(rsp_data), 64'd0);
    @(posedge clk);
    #3 reset = 1'b0;

    for (int a = 0; a < DEPTH; a++)
      push(0, TW'(a), 1'b1, AWD'(a), 32'hA500_0000 | DW'(a));
    wait_idle(2000);

    // asynchronous reset while a read is in flight
    push(1, 16'h11, 1'b0, 31'd9, '0);
    push(2, 16'h12, 1'b0, 31'd10, '0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = busy;
    end
    chk("mid_busy", 64'(seen), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rd_en", 64'(req_rd_en), 64'd0);
    chk("mid_wr_en", 64'(rsp_wr_en), 64'd0);
    chk("mid_busy0", 64'(busy), 64'd0);
    chk("mid_done", 64'(done_count), 64'd0);
    exp_q.delete();
    m_ptr = 0;
    m_done = '0;
    @(posedge clk);
    #3 reset = 1'b0;
    wait_idle(100);
    do_reset();

    push(0, 16'd1, 1'b1, 31'd5, 32'hCAFE_0001);
    wait_idle(50);
    chk("t2_wr", 64'(last_rsp), 64'({1'b0, 2'd0, 16'd1, 32'hCAFE_0001}));
    push(0, 16'd2, 1'b0, 31'd5, '0);
    wait_idle(50);
    chk("t2_rd", 64'(last_rsp), 64'({1'b0, 2'd0, 16'd2, 32'hCAFE_0001}));
    chk("t2_done", 64'(done_count), 64'd2);

    push(0, 16'd3, 1'b1, 31'd256, 32'hDEAD_0000);
    wait_idle(50);
    chk("oob_wr", 64'(last_rsp), 64'({1'b1, 2'd0, 16'd3, 32'd0}));
    push(0, 16'd4, 1'b0, 31'd0, '0);
    wait_idle(50);
    chk("oob_rd0", 64'(last_rsp), 64'({1'b0, 2'd0, 16'd4, 32'hA500_0000}));

    // skip to ch3, wrap, then ch1, then ch2 before ch0
    gnt_log.delete();
    push(3, 16'd5, 1'b0, 31'd1, '0);
    wait_idle(50);
    push(1, 16'd6, 1'b0, 31'd2, '0);
    wait_idle(50);
    push(0, 16'd7, 1'b0, 31'd3, '0);
    push(2, 16'd8, 1'b0, 31'd4, '0);
    wait_idle(50);
    chk("skip_n", 64'(gnt_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++)
      chk("skip_gnt", 64'(gnt_log[i]), 64'(exp6[i]));

    @(negedge clk);
    force dut.r_done_count = 16'hFFFF;
    #1 release dut.r_done_count;
    m_done = 16'hFFFF;
    push(1, 16'd9, 1'b0, 31'd6, '0);
    wait_idle(50);
    chk("done_wrap", 64'(done_count), 64'd0);

    do_reset();
    gnt_log.delete();
    for (int k = 0; k < NCH; k++)
      for (int r = 0; r < 2; r++)
        push(k, TW'(16'h30 + k * 2 + r), 1'b0, AWD'(k * 8 + r), '0);
    wait_idle(200);
    chk("rr_n", 64'(gnt_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < gnt_log.size(); i++)
      chk("rr_gnt", 64'(gnt_log[i]), 64'(i % NCH));

    // backpressure held for 10 cycles in RESPOND
    bp_force = 1;
    p0 = n_pops;
    push(2, 16'h40, 1'b0, 31'd7, '0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = (n_pops != p0);
    end
    chk("bp_pop", 64'(seen), 64'd1);
    repeat (3) @(negedge clk);
    #1;
    held = rsp_data;
    chk("bp_data0", 64'(held), 64'({1'b0, 2'd2, 16'h40, 32'hA500_0007}));
    push(0, 16'h41, 1'b0, 31'd8, '0);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      chk("bp_wr_en", 64'(rsp_wr_en), 64'd0);
      chk("bp_hold", 64'(rsp_data), 64'(held));
      chk("bp_no_pop", 64'(req_rd_en), 64'd0);
    end
    bp_force = 0;
    @(negedge clk);
    #1;
    chk("bp_push", 64'(rsp_wr_en), 64'd1);
    chk("bp_push_data", 64'(rsp_data), 64'(held));
    wait_idle(50);

    rand_bp = 1;
    for (int t = 0; t < 600; t++) begin
      int tot;
      logic [AWD-1:0] a;
      @(negedge clk);
      #1;
      tot = 0;
      for (int j = 0; j < NCH; j++) tot += q[j].size();
      if (tot < 5 && $urandom_range(0, 1) == 1) begin
        a = ($urandom_range(0, 9) == 0) ? AWD'($urandom)
                                         : AWD'($urandom_range(0, 299));
        push(int'($urandom_range(0, NCH - 1)), TW'($urandom),
             1'($urandom), a, DW'($urandom));
      end
    end
    rand_bp = 0;
    wait_idle(1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
